// File: rtl/lc3_dbg_pkg.sv
// Shared constants and state encoding for the LC-3 register file debug dumper.
package lc3_dbg_pkg;

  localparam int          NREGS_DEF    = 8;
  localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;
  localparam int          FRAME_BYTES  = 2 * NREGS_DEF + 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CAP  = 3'd1,
    ST_HDR  = 3'd2,
    ST_HI   = 3'd3,
    ST_LO   = 3'd4,
    ST_CSUM = 3'd5,
    ST_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/lc3_regfile_dumper.sv
// Snapshots R0..R(NREGS-1) through the regfile display port, then streams
// them as a header/data/checksum byte frame over valid/ready.
module lc3_regfile_dumper
  import lc3_dbg_pkg::*;
#(
  parameter int         NREGS    = NREGS_DEF,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  ui_sel,
  output logic [3:0]  rd_sel,
  input  logic [15:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam int IDX_W = $clog2(NREGS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NREGS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cap_we;
  logic             xfer;
  logic [15:0]      snap_q [NREGS];

  assign xfer = tx_valid_q & tx_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    cap_we  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_CAP;
        idx_d   = '0;
      end
      ST_CAP: begin
        cap_we = 1'b1;
        if (idx_q == LAST) state_d = ST_HDR;
        else               idx_d   = idx_q + IDX_W'(1);
      end
      ST_HDR: if (xfer) begin
        csum_d  = HDR_BYTE;
        idx_d   = '0;
        state_d = ST_HI;
      end
      ST_HI: if (xfer) begin
        csum_d  = csum_q ^ tx_data_q;
        state_d = ST_LO;
      end
      ST_LO: if (xfer) begin
        csum_d = csum_q ^ tx_data_q;
        if (idx_q == LAST) state_d = ST_CSUM;
        else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_HI;
        end
      end
      ST_CSUM: if (xfer) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with state_q.
    tx_valid_d = (state_d == ST_HDR) || (state_d == ST_HI) ||
                 (state_d == ST_LO)  || (state_d == ST_CSUM);
    case (state_d)
      ST_HDR:  tx_data_d = HDR_BYTE;
      ST_HI:   tx_data_d = snap_q[idx_d][15:8];
      ST_LO:   tx_data_d = snap_q[idx_d][7:0];
      ST_CSUM: tx_data_d = csum_d;
      default: tx_data_d = 8'h00;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      csum_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Snapshot buffer is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (cap_we) snap_q[idx_q] <= rd_data;
  end

  assign rd_sel   = (state_q == ST_CAP) ? 4'(idx_q) : ui_sel;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lc3_regfile_dumper.sv
// Randomized bench for lc3_regfile_dumper with a frame-level reference model.
module tb_lc3_regfile_dumper;
  import lc3_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tx_ready = 1'b1;
  logic [3:0]  ui_sel = 4'd0;
  logic [3:0]  rd_sel;
  logic [15:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done;

  logic [15:0] rf [8];
  logic        wr_en = 1'b0;
  logic [2:0]  wr_sel = 3'd0;
  logic [15:0] wr_val = 16'h0;
  int          ready_mode = 0;
  int          n_cmp = 0, n_bad = 0;
  bit          chk_en = 1'b0;

  lc3_regfile_dumper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ui_sel(ui_sel), .rd_sel(rd_sel),
    .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Regfile stand-in: combinational read, write lands on the clock edge.
  assign rd_data = rd_sel[3] ? 16'h0000 : rf[rd_sel[2:0]];
  always @(posedge clk) if (wr_en) rf[wr_sel] <= wr_val;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void build_frame(input logic [15:0] regs [8], output logic [7:0] q [$]);
    logic [7:0] x;
    q.delete();
    q.push_back(8'hA5);
    x = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      q.push_back(regs[k][15:8]);
      q.push_back(regs[k][7:0]);
      x = x ^ regs[k][15:8] ^ regs[k][7:0];
    end
    q.push_back(x);
  endfunction

  // Reference model: what the block must show in each cycle.
  bit          m_busy = 0, m_done = 0, m_stream = 0;
  int          m_cap = -1;
  logic [15:0] m_snap [8];
  logic [7:0]  exp_q [$];
  logic [7:0]  obs_q [$];
  bit          p_v = 0, p_r = 0, p_rst = 0, p_busy = 0;
  logic [7:0]  p_d = 8'h0;
  int          busy_rises = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_sel", 32'(rd_sel), (m_cap >= 0) ? 32'(m_cap) : 32'(ui_sel));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("tx_valid", 32'(tx_valid), 32'(m_stream));
      if (m_stream) check("tx_data", 32'(tx_data), 32'(exp_q[0]));
      if (p_rst && p_v && !p_r && tx_valid) check("stable", 32'(tx_data), 32'(p_d));
      if (busy && !p_busy) busy_rises++;
    end
    if (tx_valid && tx_ready && rst_n) obs_q.push_back(tx_data);
    p_v = tx_valid; p_r = tx_ready; p_d = tx_data; p_rst = rst_n; p_busy = busy;

    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_stream = 0; m_cap = -1; exp_q.delete();
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (start) begin m_busy = 1; m_cap = 0; end
    end else if (m_cap >= 0) begin
      m_snap[m_cap] = rf[m_cap];
      m_cap++;
      if (m_cap == 8) begin
        m_cap = -1;
        build_frame(m_snap, exp_q);
        m_stream = 1;
      end
    end else if (m_stream && tx_ready) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin m_stream = 0; m_done = 1; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_frame(input bit rnd_wr, output int cyc);
    cyc = 0;
    while (!done && cyc < 400) begin
      if (rnd_wr) begin
        wr_en  = 1'($urandom_range(0, 1));
        wr_sel = 3'($urandom_range(0, 7));
        wr_val = 16'($urandom);
      end
      tick(1);
      cyc++;
    end
    wr_en = 1'b0;
    check("frame_timeout", 32'(cyc < 400), 32'd1);
    tick(1);
  endtask

  initial begin
    int cyc;
    logic [7:0]  fq [$];
    logic [15:0] pin [8];

    for (int k = 0; k < 8; k++) rf[k] = 16'h0;
    // Pin the model's frame builder with hand-computed checksums.
    for (int k = 0; k < 8; k++) pin[k] = 16'(k * 16'h1111);
    build_frame(pin, fq);
    check("model_len", 32'(fq.size()), 32'(FRAME_BYTES));
    check("model_csum1", 32'(fq[17]), 32'hA5);
    for (int k = 0; k < 8; k++) pin[k] = (k == 3) ? 16'hBEEF : 16'h0;
    build_frame(pin, fq);
    check("model_csum2", 32'(fq[17]), 32'hF4);

    tick(3);
    chk_en = 1'b1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: incrementing pattern, ready always high
    for (int k = 0; k < 8; k++) rf[k] = 16'(k * 16'h1111);
    obs_q.delete();
    pulse_start();
    wait_frame(0, cyc);
    check("t1_cycles", 32'(cyc), 32'd26);
    check("t1_len", 32'(obs_q.size()), 32'd18);
    if (obs_q.size() == 18) begin
      check("t1_hdr", 32'(obs_q[0]), 32'hA5);
      check("t1_r3hi", 32'(obs_q[7]), 32'h33);
      check("t1_csum", 32'(obs_q[17]), 32'hA5);
    end
    check("t1_busy_after", 32'(busy), 32'd0);

    // 2: single nonzero register, ready toggling
    for (int k = 0; k < 8; k++) rf[k] = 16'h0;
    rf[3] = 16'hBEEF;
    ready_mode = 1;
    obs_q.delete();
    pulse_start();
    wait_frame(0, cyc);
    check("t2_len", 32'(obs_q.size()), 32'd18);
    if (obs_q.size() == 18) begin
      check("t2_b7", 32'(obs_q[7]), 32'hBE);
      check("t2_b8", 32'(obs_q[8]), 32'hEF);
      check("t2_csum", 32'(obs_q[17]), 32'hF4);
    end

    // 3: R0 write lands on the edge that captures it
    ready_mode = 0;
    tick(1);
    rf[3] = 16'h0;
    obs_q.delete();
    pulse_start();
    wr_en = 1'b1; wr_sel = 3'd0; wr_val = 16'hFFFF;
    tick(1);
    wr_en = 1'b0;
    wait_frame(0, cyc);
    if (obs_q.size() == 18) begin
      check("t3_r0hi", 32'(obs_q[1]), 32'h00);
      check("t3_r0lo", 32'(obs_q[2]), 32'h00);
    end
    check("t3_rf0", 32'(rf[0]), 32'hFFFF);

    // 4: ui_sel passthrough around a capture
    ui_sel = 4'd5;
    tick(1);
    check("t4_idle_sel", 32'(rd_sel), 32'd5);
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      check("t4_cap_sel", 32'(rd_sel), 32'(k));
      tick(1);
    end
    wait_frame(0, cyc);
    check("t4_after_sel", 32'(rd_sel), 32'd5);

    // 5: reset while R4 high byte is on the wire
    for (int k = 0; k < 8; k++) rf[k] = 16'($urandom);
    obs_q.delete();
    pulse_start();
    cyc = 0;
    while (obs_q.size() < 9 && cyc < 100) begin tick(1); cyc++; end
    check("t5_reach", 32'(cyc < 100), 32'd1);
    check("t5_r4hi", 32'(tx_data), 32'(rf[4][15:8]));
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("t5_valid", 32'(tx_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      check("t5_no_done", 32'(done), 32'd0);
      tick(1);
    end
    obs_q.delete();
    pulse_start();
    wait_frame(0, cyc);
    check("t5_len", 32'(obs_q.size()), 32'd18);

    // 6: start held for 30 cycles
    busy_rises = 0;
    start = 1'b1;
    tick(30);
    start = 1'b0;
    wait_frame(0, cyc);
    tick(2);
    check("t6_frames", 32'(busy_rises), 32'd2);

    // Randomized frames with random writes and random backpressure
    ready_mode = 2;
    repeat (8) begin
      for (int k = 0; k < 8; k++) rf[k] = 16'($urandom);
      ui_sel = 4'($urandom_range(0, 15));
      tick($urandom_range(0, 3));
      obs_q.delete();
      pulse_start();
      wait_frame(1, cyc);
      check("rnd_len", 32'(obs_q.size()), 32'd18);
    end

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
